mfp_uart_transmitter: RTL and testbench



---
 rtl/mfp_uart_transmitter.sv | 131 +++++++++++++
 tb/tb_mfp_uart_transmitter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_uart_transmitter.sv
// 8N1 UART transmitter, LSB first, fed by a small circular write FIFO.
// UART_TX comes straight from a flop; bit timing is a down-counter of DIV cycles.
module mfp_uart_transmitter #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          SI_ClkIn,
  input  logic                          SI_Reset,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  output logic                          UART_TX,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [AW:0]     wr_ptr_reg, rd_ptr_reg;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [7:0]      shift_reg, shift_next;
  logic [2:0]      bit_idx_reg, bit_idx_next;
  logic            tx_reg, tx_next;
  logic            full, empty, push, pop, bit_end;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign full       = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                      (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign push       = wr_valid & ~full;
  assign bit_end    = (cnt_reg == '0);
  assign wr_ready   = ~full;
  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
  assign busy       = (state_reg != IDLE) | ~empty;
  assign UART_TX    = tx_reg;

  always_ff @(posedge SI_ClkIn) begin
    if (SI_Reset) begin
      state_reg   <= IDLE;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      cnt_reg     <= '0;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      shift_reg   <= shift_next;
      bit_idx_reg <= bit_idx_next;
      tx_reg      <= tx_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge SI_ClkIn) begin
    if (push && !SI_Reset) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!empty) state_next = START;
      START:   if (bit_end) state_next = DATA;
      DATA:    if (bit_end && bit_idx_reg == 3'd7) state_next = STOP;
      STOP:    if (bit_end) state_next = empty ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop          = 1'b0;
    tx_next      = tx_reg;
    shift_next   = shift_reg;
    bit_idx_next = bit_idx_reg;
    cnt_next     = bit_end ? cnt_reg : cnt_reg - CW'(1);
    case (state_reg)
      IDLE: begin
        tx_next  = 1'b1;
        cnt_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg[AW-1:0]];
          tx_next    = 1'b0;
          cnt_next   = CNT_RELOAD;
        end
      end
      START: if (bit_end) begin
        tx_next      = shift_reg[0];
        bit_idx_next = 3'd0;
        cnt_next     = CNT_RELOAD;
      end
      DATA: if (bit_end) begin
        shift_next = {1'b0, shift_reg[7:1]};
        cnt_next   = CNT_RELOAD;
        if (bit_idx_reg == 3'd7) begin
          tx_next = 1'b1;
        end else begin
          // shift_reg[1] is the bit that becomes shift[0] after this shift
          bit_idx_next = bit_idx_reg + 3'd1;
          tx_next      = shift_reg[1];
        end
      end
      STOP: if (bit_end) begin
        if (!empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg[AW-1:0]];
          tx_next    = 1'b0;
          cnt_next   = CNT_RELOAD;
        end else begin
          tx_next  = 1'b1;
          cnt_next = '0;
        end
      end
      default: begin
        tx_next  = 1'b1;
        cnt_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// Scoreboard bench: accepted bytes are queued, a line monitor decodes frames and
// also tracks FIFO occupancy from accepts and observed start bits.
module tb_mfp_uart_transmitter;

  localparam int DIV   = 8;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, tx, busy;
  logic [2:0] fifo_count;

  mfp_uart_transmitter #(
    .CLK_FREQ(8), .BAUD_RATE(1), .FIFO_DEPTH(DEPTH)
  ) dut (
    .SI_ClkIn(clk), .SI_Reset(srst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .UART_TX(tx), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  logic [7:0] exp_q [$];
  int   start_q [$];
  int   last_accept = 0;
  int   frames = 0;
  bit   saw_full = 1'b0;
  int   model_count = 0;
  bit   pend = 1'b0;
  bit   in_frame = 1'b0;
  int   nsamp = 0;
  logic samp [FRAME];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cycle, act, exp);
    end
  endtask

  // Line monitor and occupancy model
  initial begin
    bit         shape_ok;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (srst) begin
        exp_q.delete();
        model_count = 0;
        pend = 1'b0;
        in_frame = 1'b0;
        nsamp = 0;
      end else begin
        if (pend) model_count++;
        if (!in_frame && tx == 1'b0) begin
          in_frame = 1'b1;
          nsamp = 0;
          model_count--;
          start_q.push_back(cycle);
        end
        check("fifo_count", int'(fifo_count), model_count);
        check("wr_ready", int'(wr_ready), int'(model_count < DEPTH));
        check("busy", int'(busy), int'(in_frame || model_count > 0));
        if (!wr_ready) saw_full = 1'b1;
        if (in_frame) begin
          samp[nsamp] = tx;
          nsamp++;
          if (nsamp == FRAME) begin
            shape_ok = 1'b1;
            for (int b = 0; b < 10; b++)
              for (int k = 1; k < DIV; k++)
                if (samp[b*DIV+k] !== samp[b*DIV]) shape_ok = 1'b0;
            check("bit_timing", int'(shape_ok), 1);
            check("stop_bit", int'(samp[9*DIV]), 1);
            for (int i = 0; i < 8; i++) got[i] = samp[(i+1)*DIV];
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_frame: cycle %0d got 0x%0h expected none", cycle, got);
            end else begin
              check("frame_data", int'(got), int'(exp_q.pop_front()));
            end
            frames++;
            $display("frame %0d: byte 0x%02h ended at cycle %0d", frames, got, cycle);
            in_frame = 1'b0;
          end
        end
        pend = wr_valid && wr_ready;
        if (pend) begin
          exp_q.push_back(wr_data);
          last_accept = cycle;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_seq(input logic [7:0] bytes [8], input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = bytes[i];
      w = 0;
      @(negedge clk);
      while (!wr_ready && w < 2000) begin
        @(negedge clk);
        w++;
      end
      check("accept_timeout", int'(wr_ready), 1);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((busy || in_frame || exp_q.size() != 0) && w < 5000);
    check("drain_timeout", int'(w >= 5000), 0);
    tick();
  endtask

  task automatic wait_cycle(input int target);
    do @(negedge clk); while (cycle < target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: cycle %0d got timeout expected finish", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes [8];
    int a0, s0, fc;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("reset_tx", int'(tx), 1);
    check("reset_count", int'(fifo_count), 0);
    check("reset_ready", int'(wr_ready), 1);
    check("reset_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    tick();

    // Single byte from idle: latency and shape
    start_q.delete();
    bytes[0] = 8'h55;
    send_seq(bytes, 1);
    a0 = last_accept;
    wait_idle();
    check("frames_55", start_q.size(), 1);
    if (start_q.size() >= 1) check("latency_55", start_q[0] - a0, 2);

    // Two consecutive writes give contiguous frames
    start_q.delete();
    bytes[0] = 8'hA3; bytes[1] = 8'h0F;
    send_seq(bytes, 2);
    wait_idle();
    check("frames_pair", start_q.size(), 2);
    if (start_q.size() >= 2) check("pair_gap", start_q[1] - start_q[0], FRAME);

    // Six bytes with valid held: FIFO fills, last byte is held off
    saw_full = 1'b0;
    fc = frames;
    for (int i = 0; i < 6; i++) bytes[i] = 8'(8'h11 * (i + 1));
    send_seq(bytes, 6);
    wait_idle();
    check("saw_full", int'(saw_full), 1);
    check("frames_six", frames - fc, 6);

    // Reset in the middle of a data bit with two bytes queued
    start_q.delete();
    bytes[0] = 8'hFF; bytes[1] = 8'hC3; bytes[2] = 8'h3C;
    send_seq(bytes, 3);
    repeat (4) @(negedge clk);
    check("queued_before_reset", int'(fifo_count), 2);
    s0 = (start_q.size() > 0) ? start_q[0] : cycle;
    wait_cycle(s0 + 27);
    tick();
    srst = 1'b1; wr_valid = 1'b1; wr_data = 8'h77;
    fc = frames;
    tick();
    srst = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_count", int'(fifo_count), 0);
    check("rst_busy", int'(busy), 0);
    repeat (200) @(negedge clk);
    check("no_frames_after_reset", frames - fc, 0);
    tick();

    // Push on the STOP->START pop edge keeps fifo_count at 2
    start_q.delete();
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56;
    send_seq(bytes, 3);
    repeat (4) @(negedge clk);
    s0 = (start_q.size() > 0) ? start_q[0] : cycle;
    wait_cycle(s0 + 78);
    tick();
    wr_valid = 1'b1; wr_data = 8'h5A;
    @(negedge clk);
    tick();
    wr_valid = 1'b0;
    @(negedge clk);
    check("same_edge_count", int'(fifo_count), 2);
    check("same_edge_start", int'(start_q.size() >= 2 && start_q[1] == s0 + FRAME), 1);
    wait_idle();

    // Randomised traffic with random gaps
    for (int i = 0; i < 40; i++) begin
      bytes[0] = 8'($urandom_range(0, 255));
      send_seq(bytes, 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 120)) tick();
    end
    wait_idle();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
